vga_scan_gen: RTL and testbench

Raster scan generator for the hourglass display path. It divides the board clock down to a pixel tick and runs the horizontal and vertical counters. It drives the `visible_col`/`visible_row` buses consumed by the brick/shape flag stages (bottle, neck, sand), and produces `hsync`/`vsync`/`video_on` delayed to line up with those stages' registered flags at the colour mux.

---
 rtl/vga_scan_gen.sv | 118 +++++++++++
 tb/tb_vga_scan_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// vga_scan_gen -- raster scan generator.
// Divides clk down to a pixel tick, runs the h/v counters and drives
// registered position buses plus hsync/vsync/video_on, delayed to line
// up with the downstream flag stages at the colour mux.
// Ports:
//   clk          board clock
//   BTN_S        synchronous active-high reset
//   visible_col  pixel column, 2047 outside the visible area
//   visible_row  pixel row, 2047 outside the visible area
//   pix_tick     one-clk pulse per pixel
//   frame_start  one-clk pulse when the counters enter (0,0)
//   video_on     visible-area flag, SYNC_DELAY clks late
//   hsync/vsync  sync outputs, SYNC_DELAY clks late
module vga_scan_gen #(
  parameter int   CLK_DIV     = 2,
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   SYNC_DELAY  = 1
) (
  input  logic        clk,
  input  logic        BTN_S,
  output logic [10:0] visible_col,
  output logic [10:0] visible_row,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [10:0] H_TOTAL  = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOTAL  = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [10:0] OFFSCREEN = 11'd2047;

  // delay-line word: {video_on, hsync, vsync}
  localparam logic [2:0] FLAGS_IDLE = {1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE};

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      h_q, h_d, v_q, v_d;
  logic [10:0]      col_q, col_d, row_q, row_d;
  logic             tick_q, fs_q, fs_d;
  logic             tick;
  logic             vis_d;
  logic [2:0]       raw_d;
  logic [2:0]       dly_q [SYNC_DELAY+1];

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_TOTAL - 11'd1) begin
        h_d = '0;
        v_d = (v_q == V_TOTAL - 11'd1) ? 11'd0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
    // everything below is derived from the next position so the outputs
    // move in the same edge as the counters
    vis_d    = (h_d < H_VIS) && (v_d < V_VIS);
    col_d    = vis_d ? h_d : OFFSCREEN;
    row_d    = vis_d ? v_d : OFFSCREEN;
    raw_d[2] = vis_d;
    raw_d[1] = ((h_d >= HS_START) && (h_d < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    raw_d[0] = ((v_d >= VS_START) && (v_d < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    fs_d     = tick && (h_d == 11'd0) && (v_d == 11'd0);
  end

  always_ff @(posedge clk) begin
    if (BTN_S) begin
      // parked on the last pixel so the first tick wraps into (0,0)
      div_q  <= '0;
      h_q    <= H_TOTAL - 11'd1;
      v_q    <= V_TOTAL - 11'd1;
      col_q  <= OFFSCREEN;
      row_q  <= OFFSCREEN;
      tick_q <= 1'b0;
      fs_q   <= 1'b0;
      for (int i = 0; i <= SYNC_DELAY; i++) dly_q[i] <= FLAGS_IDLE;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      col_q  <= col_d;
      row_q  <= row_d;
      // registered copy of (div_cnt == CLK_DIV-1)
      tick_q <= (div_d == DIV_LAST);
      fs_q   <= fs_d;
      dly_q[0] <= raw_d;
      for (int i = 1; i <= SYNC_DELAY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign visible_col = col_q;
  assign visible_row = row_q;
  assign pix_tick    = tick_q;
  assign frame_start = fs_q;
  assign {video_on, hsync, vsync} = dly_q[SYNC_DELAY];

endmodule

// File: tb/tb_vga_scan_gen.sv
module tb_vga_scan_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // three instances: defaults, a tiny CLK_DIV=1/SYNC_DELAY=0 corner, and a
  // tiny CLK_DIV=3/SYNC_DELAY=4/active-high-sync variant
  logic [10:0] col0, row0, col1, row1, col2, row2;
  logic tk0, fs0, vo0, hs0, vs0;
  logic tk1, fs1, vo1, hs1, vs1;
  logic tk2, fs2, vo2, hs2, vs2;

  vga_scan_gen dut0 (
    .clk(clk), .BTN_S(rst), .visible_col(col0), .visible_row(row0),
    .pix_tick(tk0), .frame_start(fs0), .video_on(vo0), .hsync(hs0), .vsync(vs0));

  vga_scan_gen #(.CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                 .SYNC_ACTIVE(1'b0), .SYNC_DELAY(0)) dut1 (
    .clk(clk), .BTN_S(rst), .visible_col(col1), .visible_row(row1),
    .pix_tick(tk1), .frame_start(fs1), .video_on(vo1), .hsync(hs1), .vsync(vs1));

  vga_scan_gen #(.CLK_DIV(3), .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
                 .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                 .SYNC_ACTIVE(1'b1), .SYNC_DELAY(4)) dut2 (
    .clk(clk), .BTN_S(rst), .visible_col(col2), .visible_row(row2),
    .pix_tick(tk2), .frame_start(fs2), .video_on(vo2), .hsync(hs2), .vsync(vs2));

  // clk edges since reset was last sampled high (0 right after a reset edge)
  int k = 0;
  always @(posedge clk) begin
    if (rst) k = 0;
    else     k = k + 1;
  end

  // Expected outputs after k edges, from the timing rules: ticks arrive at
  // every CLK_DIV-th edge; tick n places the raster at linear index n-1 (mod
  // frame size) since reset parks it on the last pixel. Flags see the
  // position SYNC_DELAY edges earlier. Packed {col,row,tick,fs,von,hs,vs}.
  function automatic logic [26:0] model(int d, int hv, int hf, int hs, int hb,
                                        int vv, int vf, int vs, int vb,
                                        bit sa, int sd, int kk);
    int ht = hv + hf + hs + hb;
    int fr = ht * (vv + vf + vs + vb);
    int n, l, h, v, m;
    logic [10:0] c, r;
    logic t, f, von, hsy, vsy;
    n = kk / d;
    l = (n + fr - 1) % fr;
    h = l % ht; v = l / ht;
    c = (h < hv && v < vv) ? 11'(h) : 11'd2047;
    r = (h < hv && v < vv) ? 11'(v) : 11'd2047;
    t = (kk >= 1) && (kk % d == d - 1);
    f = (kk >= 1) && (kk % d == 0) && (l == 0);
    m = (kk - sd < 0) ? 0 : kk - sd;
    n = m / d;
    l = (n + fr - 1) % fr;
    h = l % ht; v = l / ht;
    von = (h < hv) && (v < vv);
    hsy = (h >= hv + hf && h < hv + hf + hs) ? sa : ~sa;
    vsy = (v >= vv + vf && v < vv + vf + vs) ? sa : ~sa;
    return {c, r, t, f, von, hsy, vsy};
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%0d expected=%0d", nm, k, got, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input logic [26:0] got, input logic [26:0] e);
    check({tag, ".col"},   int'(got[26:16]), int'(e[26:16]));
    check({tag, ".row"},   int'(got[15:5]),  int'(e[15:5]));
    check({tag, ".tick"},  int'(got[4]),     int'(e[4]));
    check({tag, ".fs"},    int'(got[3]),     int'(e[3]));
    check({tag, ".von"},   int'(got[2]),     int'(e[2]));
    check({tag, ".hsync"}, int'(got[1]),     int'(e[1]));
    check({tag, ".vsync"}, int'(got[0]),     int'(e[0]));
  endtask

  // per-cycle scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_all("d0", {col0, row0, tk0, fs0, vo0, hs0, vs0},
              model(2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1, k));
      cmp_all("d1", {col1, row1, tk1, fs1, vo1, hs1, vs1},
              model(1, 8, 2, 3, 2, 6, 1, 2, 2, 1'b0, 0, k));
      cmp_all("d2", {col2, row2, tk2, fs2, vo2, hs2, vs2},
              model(3, 10, 2, 3, 1, 4, 1, 2, 1, 1'b1, 4, k));
    end
  end

  initial begin
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk_en = 1'b1;
    // hand-computed anchors for the default instance
    check("lit.rst_hsync", int'(hs0), 1);
    check("lit.rst_vsync", int'(vs0), 1);
    check("lit.rst_col", int'(col0), 2047);
    rst = 1'b0;
    for (int c = 0; c < 1700; c++) begin
      @(negedge clk);
      case (k)
        1:    begin check("lit.k1_col", int'(col0), 2047); check("lit.k1_fs", int'(fs0), 0); end
        2:    begin check("lit.k2_fs", int'(fs0), 1); check("lit.k2_col", int'(col0), 0);
                    check("lit.k2_row", int'(row0), 0); check("lit.k2_von", int'(vo0), 0);
                    check("lit.k2_d1_col", int'(col1), 1); end
        3:    begin check("lit.k3_von", int'(vo0), 1); check("lit.k3_fs", int'(fs0), 0); end
        1281: check("lit.col639", int'(col0), 639);
        1282: check("lit.col_blank", int'(col0), 2047);
        1314: check("lit.hs_before", int'(hs0), 1);
        1315: check("lit.hs_fall", int'(hs0), 0);
        1506: check("lit.hs_last", int'(hs0), 0);
        1507: check("lit.hs_rise", int'(hs0), 1);
        1602: begin check("lit.line2_col", int'(col0), 0); check("lit.line2_row", int'(row0), 1); end
        default: ;
      endcase
    end
    // random run with occasional short mid-frame resets
    for (int c = 0; c < 60000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 4999) == 0) rst = 1'b1;
      else if ($urandom_range(0, 3) == 0 && k < 3 && k > 0) rst = 1'b1;
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
